inv_mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/inv_mix_columns_seq_if.sv | 30 +++
 rtl/inv_mix_column.sv | 26 ++
 rtl/mul11.sv | 14 +
 rtl/mul13.sv | 14 +
 rtl/mul14.sv | 14 +
 rtl/mul9.sv | 14 +
 rtl/inv_mix_columns_seq.sv | 106 ++++++++++
 tb/tb_inv_mix_columns_seq.sv | 233 +++++++++++++++++++++++
 9 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse round datapath.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } imc_state_t;

    // Multiply by 02 modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Valid/ready handshake bundle for the iterative InvMixColumns engine.
interface inv_mix_columns_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on a single 32-bit column (row 0 in the top byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  column_t col_i,
    output column_t col_o
);
    byte_t a   [4];
    byte_t m9  [4];
    byte_t m11 [4];
    byte_t m13 [4];
    byte_t m14 [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign a[i] = col_i[31-8*i -: 8];
        mul9  u_mul9  (.a_i(a[i]), .p_o(m9[i]));
        mul11 u_mul11 (.a_i(a[i]), .p_o(m11[i]));
        mul13 u_mul13 (.a_i(a[i]), .p_o(m13[i]));
        mul14 u_mul14 (.a_i(a[i]), .p_o(m14[i]));
    end

    assign col_o[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    assign col_o[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    assign col_o[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    assign col_o[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
endmodule

// File: rtl/mul11.sv
// Constant GF(2^8) multiply by 0b.
module mul11
    import aes_pkg::*;
(
    input  byte_t a_i,
    output byte_t p_o
);
    byte_t x2, x4, x8;

    assign x2  = xtime(a_i);
    assign x4  = xtime(x2);
    assign x8  = xtime(x4);
    assign p_o = x8 ^ x2 ^ a_i;
endmodule

// File: rtl/mul13.sv
// Constant GF(2^8) multiply by 0d.
module mul13
    import aes_pkg::*;
(
    input  byte_t a_i,
    output byte_t p_o
);
    byte_t x2, x4, x8;

    assign x2  = xtime(a_i);
    assign x4  = xtime(x2);
    assign x8  = xtime(x4);
    assign p_o = x8 ^ x4 ^ a_i;
endmodule

// File: rtl/mul14.sv
// Constant GF(2^8) multiply by 0e.
module mul14
    import aes_pkg::*;
(
    input  byte_t a_i,
    output byte_t p_o
);
    byte_t x2, x4, x8;

    assign x2  = xtime(a_i);
    assign x4  = xtime(x2);
    assign x8  = xtime(x4);
    assign p_o = x8 ^ x4 ^ x2;
endmodule

// File: rtl/mul9.sv
// Constant GF(2^8) multiply by 09.
module mul9
    import aes_pkg::*;
(
    input  byte_t a_i,
    output byte_t p_o
);
    byte_t x2, x4, x8;

    assign x2  = xtime(a_i);
    assign x4  = xtime(x2);
    assign x8  = xtime(x4);
    assign p_o = x8 ^ a_i;
endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: transforms COLS_PER_CYCLE columns of the held state per clock.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clear,
    inv_mix_columns_seq_if.slave bus
);
    if (!(COLS_PER_CYCLE inside {1, 2, 4})) begin : g_bad_cols
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    imc_state_t state_q, state_d;
    state_t     st_q, st_d;
    logic [1:0] col_cnt_q, col_cnt_d;

    column_t    st_cols   [NUM_COLS];
    column_t    calc_cols [NUM_COLS];
    state_t     calc_st;
    logic [1:0] col_idx   [COLS_PER_CYCLE];
    column_t    col_in    [COLS_PER_CYCLE];
    column_t    col_out   [COLS_PER_CYCLE];
    logic [2:0] cnt_sum;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_cols
        assign st_cols[c] = st_q[127-32*c -: 32];
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_imc
        assign col_idx[g] = col_cnt_q + 2'(g);
        assign col_in[g]  = st_cols[col_idx[g]];
        inv_mix_column u_imc (
            .col_i (col_in[g]),
            .col_o (col_out[g])
        );
    end

    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            calc_cols[c] = st_cols[c];
        end
        for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
            calc_cols[col_idx[g]] = col_out[g];
        end
    end

    assign calc_st = {calc_cols[0], calc_cols[1], calc_cols[2], calc_cols[3]};
    // Bit 2 of the sum marks the pass that completes column 3.
    assign cnt_sum = {1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE);

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        col_cnt_d = col_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d      = bus.in_data;
                    col_cnt_d = 2'd0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                st_d      = calc_st;
                col_cnt_d = cnt_sum[1:0];
                if (cnt_sum[2]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d   = IDLE;
            st_d      = st_q;
            col_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            st_q      <= '0;
            col_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = st_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Runs COLS_PER_CYCLE = 1, 2 and 4 side by side against a matrix-level reference model.
module tb_inv_mix_columns_seq;
    import aes_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   clear;
    logic   in_valid;
    logic   out_ready;
    state_t in_data;

    always #5 clk = ~clk;

    inv_mix_columns_seq_if u_if1 ();
    inv_mix_columns_seq_if u_if2 ();
    inv_mix_columns_seq_if u_if4 ();

    assign u_if1.in_valid  = in_valid;
    assign u_if1.in_data   = in_data;
    assign u_if1.out_ready = out_ready;
    assign u_if2.in_valid  = in_valid;
    assign u_if2.in_data   = in_data;
    assign u_if2.out_ready = out_ready;
    assign u_if4.in_valid  = in_valid;
    assign u_if4.in_data   = in_data;
    assign u_if4.out_ready = out_ready;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .bus(u_if1.slave));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .bus(u_if2.slave));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .clear(clear), .bus(u_if4.slave));

    logic [2:0] ov, ir;
    state_t     od [3];
    assign ov    = {u_if4.out_valid, u_if2.out_valid, u_if1.out_valid};
    assign ir    = {u_if4.in_ready, u_if2.in_ready, u_if1.in_ready};
    assign od[0] = u_if1.out_data;
    assign od[1] = u_if2.out_data;
    assign od[2] = u_if4.out_data;

    int checks = 0;
    int errors = 0;
    int exp_lat [3] = '{4, 2, 1};
    int ncols   [3] = '{1, 2, 4};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        byte_t y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (byte_t'({x[6:0], 1'b0}) ^ 8'h1b) : byte_t'({x[6:0], 1'b0});
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic state_t ref_imc(input state_t s);
        byte_t  base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        state_t r = '0;
        byte_t  acc;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8], base[(j - row + 4) % 4]);
                end
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Columns below n come from the transformed state, the rest from the original.
    function automatic state_t partial(input state_t s, input int n);
        state_t full = ref_imc(s);
        state_t r    = s;
        for (int c = 0; c < n; c++) begin
            r[127-32*c -: 32] = full[127-32*c -: 32];
        end
        return r;
    endfunction

    function automatic state_t rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_state(input string tag, input state_t s, input state_t exp, input int hold);
        int     lat [3];
        check({tag, ":idle_ready"}, 128'(ir), 128'(3'b111));
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
        in_data  = rand_state();
        lat      = '{0, 0, 0};
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) check({tag, ":busy_ready"}, 128'(ir), 128'(3'b000));
            for (int j = 0; j < 3; j++) begin
                if (lat[j] == 0 && ov[j]) lat[j] = k;
            end
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("%s:latency%0d", tag, ncols[j]), 128'(lat[j]), 128'(exp_lat[j]));
            check($sformatf("%s:data%0d", tag, ncols[j]), od[j], exp);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            in_data  = rand_state();
            step();
            check($sformatf("%s:hold_valid%0d", tag, h), 128'(ov), 128'(3'b111));
            check($sformatf("%s:hold_ready%0d", tag, h), 128'(ir), 128'(3'b000));
            for (int j = 0; j < 3; j++) begin
                check($sformatf("%s:hold_data%0d_%0d", tag, h, ncols[j]), od[j], exp);
            end
        end
        // in_valid alongside out_ready must not start a new state.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, ":released_valid"}, 128'(ov), 128'(3'b000));
        check({tag, ":released_ready"}, 128'(ir), 128'(3'b111));
    endtask

    initial begin
        state_t s;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        check("reset_ready", 128'(ir), 128'(3'b111));
        check("reset_valid", 128'(ov), 128'(3'b000));
        for (int j = 0; j < 3; j++) check($sformatf("reset_data%0d", ncols[j]), od[j], '0);
        step();
        step();
        rst = 1'b0;

        run_state("kat_col", 128'h8e4da1bc_01010101_01010101_01010101,
                  128'hdb135345_01010101_01010101_01010101, 0);
        run_state("kat_full", 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8,
                  128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 10);
        run_state("fixed_c6", {16{8'hc6}}, {16{8'hc6}}, 0);
        run_state("zero", '0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            s = rand_state();
            run_state($sformatf("rand%0d", i), s, ref_imc(s), 2);
        end

        // Asynchronous reset after two compute edges.
        in_valid = 1'b1;
        in_data  = rand_state();
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midreset_ready", 128'(ir), 128'(3'b111));
        check("midreset_valid", 128'(ov), 128'(3'b000));
        for (int j = 0; j < 3; j++) check($sformatf("midreset_data%0d", ncols[j]), od[j], '0);
        step();
        rst = 1'b0;
        s = rand_state();
        run_state("after_reset", s, ref_imc(s), 0);

        // clear in DONE with out_ready high: back to IDLE, st untouched.
        s = rand_state();
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        clear     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("clear_same_cycle_valid", 128'(ov), 128'(3'b111));
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clear_done_ready", 128'(ir), 128'(3'b111));
        check("clear_done_valid", 128'(ov), 128'(3'b000));
        for (int j = 0; j < 3; j++) begin
            check($sformatf("clear_done_data%0d", ncols[j]), od[j], ref_imc(s));
        end

        // clear after one compute edge freezes the partially transformed state.
        s = rand_state();
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_calc_ready", 128'(ir), 128'(3'b111));
        for (int j = 0; j < 3; j++) begin
            check($sformatf("clear_calc_data%0d", ncols[j]), od[j], partial(s, ncols[j]));
        end

        run_state("b2b_kat", 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8,
                  128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 0);
        run_state("b2b_c6", {16{8'hc6}}, {16{8'hc6}}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end
endmodule
